// File: rtl/check_node_unit.sv
// Degree-6 min-sum check node, two-stage pipeline with saturating parity-fail counter.
// Define CNU_OFFSET_EN to build the offset min-sum variant (selected magnitude minus one, floored at zero).
module check_node_unit (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            in_valid,
   input  logic [5:0][5:0] X,
   input  logic            clr_fail,
   output logic [5:0][4:0] Y,
   output logic            out_valid,
   output logic            parity_ok,
   output logic [7:0]      fail_cnt
);

   logic [3:0] c_min1, c_min2;
   logic [2:0] c_idx1;
   logic       c_sign_all, c_hd_par;
   logic [5:0] c_signs;

   logic [3:0] s1_min1, s1_min2;
   logic [2:0] s1_idx1;
   logic       s1_sign_all, s1_hd_par, s1_v;
   logic [5:0] s1_signs;

   logic [5:0][4:0] y_next;

   // Strict compare keeps the lowest lane as idx1 on ties; the tied value falls into min2.
   always_comb begin
      c_min1     = 4'hF;
      c_min2     = 4'hF;
      c_idx1     = 3'd0;
      c_sign_all = 1'b0;
      c_hd_par   = 1'b0;
      c_signs    = '0;
      for (int i = 0; i < 6; i++) begin
         c_signs[i] = X[i][4];
         c_sign_all = c_sign_all ^ X[i][4];
         c_hd_par   = c_hd_par ^ X[i][5];
         if (X[i][3:0] < c_min1) begin
            c_min2 = c_min1;
            c_min1 = X[i][3:0];
            c_idx1 = 3'(i);
         end else if (X[i][3:0] < c_min2) begin
            c_min2 = X[i][3:0];
         end
      end
   end

   always_comb begin
      logic [3:0] mag;
      logic       sgn;
      y_next = '0;
      for (int i = 0; i < 6; i++) begin
         mag = (s1_idx1 == 3'(i)) ? s1_min2 : s1_min1;
`ifdef CNU_OFFSET_EN
         if (mag != 4'd0)
            mag = mag - 4'd1;
`endif
         sgn       = (mag == 4'd0) ? 1'b0 : (s1_sign_all ^ s1_signs[i]);
         y_next[i] = {sgn, mag};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_min1     <= '0;
         s1_min2     <= '0;
         s1_idx1     <= '0;
         s1_sign_all <= 1'b0;
         s1_signs    <= '0;
         s1_hd_par   <= 1'b0;
         s1_v        <= 1'b0;
         Y           <= '0;
         out_valid   <= 1'b0;
         parity_ok   <= 1'b0;
      end else if (en) begin
         s1_min1     <= c_min1;
         s1_min2     <= c_min2;
         s1_idx1     <= c_idx1;
         s1_sign_all <= c_sign_all;
         s1_signs    <= c_signs;
         s1_hd_par   <= c_hd_par;
         s1_v        <= in_valid;
         Y           <= y_next;
         out_valid   <= s1_v;
         parity_ok   <= ~s1_hd_par;
      end
   end

   // Clear is not gated by en and takes priority over a same-edge increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fail_cnt <= 8'd0;
      else if (clr_fail)
         fail_cnt <= 8'd0;
      else if (en && s1_v && s1_hd_par && (fail_cnt != 8'hFF))
         fail_cnt <= fail_cnt + 8'd1;
   end

endmodule

// File: tb/tb_check_node_unit.sv
// Scoreboard bench for check_node_unit; expected Y/parity come from a per-lane exclude-self reference model.
module tb_check_node_unit;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            en = 1'b0;
   logic            in_valid = 1'b0;
   logic [5:0][5:0] X = '0;
   logic            clr_fail = 1'b0;
   logic [5:0][4:0] Y;
   logic            out_valid;
   logic            parity_ok;
   logic [7:0]      fail_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   logic chk = 1'b0;
   logic [30:0] sb[$];

   check_node_unit dut (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .X(X),
      .clr_fail(clr_fail), .Y(Y), .out_valid(out_valid),
      .parity_ok(parity_ok), .fail_cnt(fail_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0][5:0] mkx(input logic [5:0] hd, input logic [5:0] sg,
                                           input logic [23:0] mg);
      logic [5:0][5:0] x;
      for (int i = 0; i < 6; i++)
         x[i] = {hd[i], sg[i], mg[4*i +: 4]};
      return x;
   endfunction

   // Each lane independently scans every other lane: minimum magnitude and sign XOR.
   function automatic logic [30:0] model(input logic [5:0][5:0] x);
      logic [5:0][4:0] y;
      logic            hp;
      logic [3:0]      m;
      logic            s;
      hp = 1'b0;
      for (int i = 0; i < 6; i++)
         hp = hp ^ x[i][5];
      for (int i = 0; i < 6; i++) begin
         m = 4'hF;
         s = 1'b0;
         for (int j = 0; j < 6; j++)
            if (j != i) begin
               if (x[j][3:0] < m) m = x[j][3:0];
               s = s ^ x[j][4];
            end
`ifdef CNU_OFFSET_EN
         m = (m == 4'd0) ? 4'd0 : m - 4'd1;
`endif
         if (m == 4'd0) s = 1'b0;
         y[i] = {s, m};
      end
      return {~hp, y};
   endfunction

   task automatic tick();
      logic [30:0] exp;
      @(posedge clk);
      chk = en && !rst;
      @(negedge clk);
      if (chk && out_valid) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_out_valid: out_valid=%b with no set expected", out_valid);
         end else begin
            exp = sb.pop_front();
            if ({parity_ok, Y} !== exp) begin
               n_fail++;
               $display("FAIL sb_Y: got parity_ok=%b Y=%h, expected parity_ok=%b Y=%h",
                        parity_ok, Y, exp[30], exp[29:0]);
            end
         end
      end
   endtask

   task automatic send(input logic [5:0][5:0] x, input logic v);
      en = 1'b1;
      X = x;
      in_valid = v;
      if (v) sb.push_back(model(x));
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send('0, 1'b0);
   endtask

   task automatic check_fc(input string name, input logic [7:0] exp);
      n_tests++;
      if (fail_cnt !== exp) begin
         n_fail++;
         $display("FAIL %s: fail_cnt=%0d expected %0d", name, fail_cnt, exp);
      end
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if ({Y, out_valid, parity_ok, fail_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: Y=%h out_valid=%b parity_ok=%b fail_cnt=%0d, expected all 0",
                  Y, out_valid, parity_ok, fail_cnt);
      end
      tick();
      tick();
      rst = 1'b0;
      idle(3);
   endtask

   task automatic test_vectors();
      send(mkx(6'b000000, 6'b000000, {4'd15, 4'd12, 4'd3, 4'd9, 4'd3, 4'd7}), 1'b1);
      send(mkx(6'b000000, 6'b011001, {4'd9, 4'd4, 4'd6, 4'd8, 4'd2, 4'd5}), 1'b1);
      send(mkx(6'b000000, 6'b000100, {4'd6, 4'd6, 4'd6, 4'd0, 4'd6, 4'd6}), 1'b1);
      send(mkx(6'b000000, 6'b000000, {4'd7, 4'd7, 4'd7, 4'd4, 4'd4, 4'd1}), 1'b1);
      send(mkx(6'b101100, 6'b111111, {4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15}), 1'b1);
      send(mkx(6'b000001, 6'b100000, {4'd1, 4'd2, 4'd1, 4'd5, 4'd0, 4'd0}), 1'b1);
      idle(2);
   endtask

   task automatic test_random();
      logic [5:0][5:0] x;
      logic            v, e;
      for (int k = 0; k < 60; k++) begin
         for (int i = 0; i < 6; i++) x[i] = 6'($urandom);
         v = ($urandom_range(3) != 0);
         e = ($urandom_range(3) != 0);
         en = e;
         X = x;
         in_valid = v;
         if (e && v) sb.push_back(model(x));
         tick();
      end
      idle(2);
   endtask

   task automatic test_fail_cnt();
      logic [5:0][5:0] bad;
      bad = mkx(6'b000001, 6'b000000, {4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8});
      clr_fail = 1'b1;
      tick();
      clr_fail = 1'b0;
      check_fc("fc_clear_initial", 8'd0);
      for (int i = 0; i < 10; i++) send(bad, 1'b1);
      idle(2);
      check_fc("fc_count_10", 8'd10);
      for (int i = 0; i < 290; i++) send(bad, 1'b1);
      idle(2);
      check_fc("fc_saturate", 8'd255);
      idle(3);
      check_fc("fc_saturate_hold", 8'd255);
      clr_fail = 1'b1;
      tick();
      clr_fail = 1'b0;
      check_fc("fc_clear_pulse", 8'd0);
      send(bad, 1'b1);
      send(bad, 1'b1);
      clr_fail = 1'b1;
      send(bad, 1'b1);
      clr_fail = 1'b0;
      check_fc("fc_clear_wins", 8'd0);
      send(bad, 1'b1);
      check_fc("fc_after_clear", 8'd1);
      en = 1'b0;
      clr_fail = 1'b1;
      tick();
      clr_fail = 1'b0;
      check_fc("fc_clear_en_low", 8'd0);
      idle(2);
      check_fc("fc_drain", 8'd1);
   endtask

   task automatic test_hold_and_reset();
      logic [5:0][5:0] p;
      logic [30:0]     exp_p;
      p = mkx(6'b000010, 6'b010010, {4'd2, 4'd9, 4'd3, 4'd11, 4'd5, 4'd4});
      exp_p = model(p);
      send(p, 1'b1);
      send(mkx(6'b000000, 6'b000001, {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3}), 1'b1);
      en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         X = mkx(6'(k + 1), 6'(7 * k), 24'($urandom));
         in_valid = 1'b1;
         tick();
         n_tests++;
         if ({out_valid, parity_ok, Y} !== {1'b1, exp_p}) begin
            n_fail++;
            $display("FAIL hold_en_low: out_valid=%b parity_ok=%b Y=%h, expected 1 %b %h",
                     out_valid, parity_ok, Y, exp_p[30], exp_p[29:0]);
         end
      end
      send(mkx(6'b110000, 6'b001100, {4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3}), 1'b1);
      send(mkx(6'b000000, 6'b111000, {4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd9}), 1'b1);
      #2 rst = 1'b1;
      #1;
      sb.delete();
      n_tests++;
      if ({Y, out_valid, parity_ok, fail_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_midstream: Y=%h out_valid=%b parity_ok=%b fail_cnt=%0d, expected all 0",
                  Y, out_valid, parity_ok, fail_cnt);
      end
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         send('0, 1'b0);
         n_tests++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_valid: out_valid=%b expected 0", out_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_random();
      test_fail_cnt();
      test_hold_and_reset();
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d expected sets never appeared, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
